// File: rtl/debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
// The state encoding is fixed so that waveform dumps read the same across builds.
package debounce_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

  // The debounced level stays high while a release is still being qualified.
  function automatic logic level_of(input db_state_e s);
    return (s == PRESSED) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer that brings an asynchronous 1-bit input into the clock domain.
// Both flops clear to 0 in reset, so a held button never looks pressed before sampling.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizes the raw input, then accepts a level change only
// after DEBOUNCE_CYCLES consecutive stable cycles, emitting one-cycle press/release strobes.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 btn_s;
  db_state_e            state;
  db_state_e            state_next;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 press_next;
  logic                 release_next;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_s)
  );

  // Outputs are registered from next-state so level and strobe rise on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      btn_level     <= level_of(state_next);
      press_pulse   <= press_next;
      release_pulse <= release_next;
    end
  end

  // Any disagreement during a wait drops back to the settled state with the count cleared.
  always_comb begin
    state_next   = state;
    cnt_next     = '0;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) state_next = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = PRESSED;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) state_next = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_next = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_next   = IDLE;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed and random-bounce bench for button_debouncer with DEBOUNCE_CYCLES = 4.
// Edges are counted from the first rising edge that samples a new btn_in level.
module tb_button_debouncer;
  import debounce_pkg::*;

  localparam int DEBOUNCE_CYCLES = 4;
  localparam int LATENCY         = DEBOUNCE_CYCLES + 3;

  logic clock = 1'b0;
  logic reset;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;

  int tests_run    = 0;
  int tests_failed = 0;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) dut (
    .clock         (clock),
    .reset         (reset),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic check_val(input string tag, input int observed, input int expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drives a new settled level and checks the 20 edges that follow against the latency.
  task automatic apply_stimulus(input logic level, input string tag);
    btn_in = level;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (level) begin
        check_bit({tag, "_press"}, press_pulse, logic'(e == LATENCY));
        check_bit({tag, "_release"}, release_pulse, 1'b0);
        check_bit({tag, "_level"}, btn_level, logic'(e >= LATENCY));
      end else begin
        check_bit({tag, "_release"}, release_pulse, logic'(e == LATENCY));
        check_bit({tag, "_press"}, press_pulse, 1'b0);
        check_bit({tag, "_level"}, btn_level, logic'(e < LATENCY));
      end
    end
  endtask

  task automatic check_quiet(input string tag, input logic level);
    check_bit({tag, "_press"}, press_pulse, 1'b0);
    check_bit({tag, "_release"}, release_pulse, 1'b0);
    check_bit({tag, "_level"}, btn_level, level);
  endtask

  initial begin
    logic exp_next_press;
    logic level_model;
    logic prev_any;
    int   run;
    int   pulses;

    reset  = 1'b0;
    btn_in = 1'b1;
    repeat (3) tick();
    check_quiet("in_reset", 1'b0);
    check_val("in_reset_state", int'(dut.state), int'(IDLE));
    check_bit("in_reset_sync", dut.btn_s, 1'b0);

    reset = 1'b1;
    apply_stimulus(1'b1, "post_reset");
    apply_stimulus(1'b0, "release_a");
    apply_stimulus(1'b1, "press_b");
    apply_stimulus(1'b0, "release_b");

    for (int e = 0; e < 16; e++) begin
      btn_in = ((e % 4) < 2);
      tick();
      check_quiet("toggle", 1'b0);
    end
    btn_in = 1'b0;
    repeat (8) begin
      tick();
      check_quiet("toggle_tail", 1'b0);
    end
    check_val("toggle_state", int'(dut.state), int'(IDLE));

    apply_stimulus(1'b1, "glitch_setup");
    btn_in = 1'b0;
    tick();
    btn_in = 1'b1;
    tick();
    check_quiet("glitch_e2", 1'b1);
    tick();
    check_val("glitch_wait_state", int'(dut.state), int'(RELEASE_WAIT));
    check_quiet("glitch_e3", 1'b1);
    repeat (7) begin
      tick();
      check_quiet("glitch_after", 1'b1);
    end
    check_val("glitch_state", int'(dut.state), int'(PRESSED));
    check_val("glitch_cnt", int'(dut.cnt), 0);

    apply_stimulus(1'b0, "glitch_exit");
    btn_in = 1'b1;
    repeat (5) tick();
    check_val("mid_wait_state", int'(dut.state), int'(PRESS_WAIT));
    check_val("mid_wait_cnt", int'(dut.cnt), 2);
    #2;
    reset = 1'b0;
    #1;
    check_val("async_rst_state", int'(dut.state), int'(IDLE));
    check_val("async_rst_cnt", int'(dut.cnt), 0);
    check_bit("async_rst_sync", dut.btn_s, 1'b0);
    check_quiet("async_rst_out", 1'b0);
    btn_in = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (10) begin
      tick();
      check_quiet("after_abandon", 1'b0);
    end
    check_val("after_abandon_state", int'(dut.state), int'(IDLE));

    apply_stimulus(1'b1, "pre_reset_press");
    #2;
    reset = 1'b0;
    #1;
    check_bit("rst_pressed_level", btn_level, 1'b0);
    check_val("rst_pressed_state", int'(dut.state), int'(IDLE));
    reset = 1'b1;
    apply_stimulus(1'b1, "held_through_reset");

    // Random bounce: a small level model tracks strobe order and the debounced level.
    exp_next_press = 1'b0;
    level_model    = 1'b1;
    prev_any       = 1'b0;
    run            = 0;
    pulses         = 0;
    for (int i = 0; i < 10000; i++) begin
      if (run == 0) begin
        btn_in = logic'($urandom_range(0, 1));
        run    = int'($urandom_range(1, 9));
      end
      run--;
      tick();
      check_bit("stress_overlap", press_pulse & release_pulse, 1'b0);
      if (press_pulse || release_pulse) begin
        pulses++;
        check_bit("stress_order", press_pulse, exp_next_press);
        check_bit("stress_width", prev_any, 1'b0);
        exp_next_press = ~exp_next_press;
        level_model    = press_pulse;
      end
      check_bit("stress_level", btn_level, level_model);
      prev_any = press_pulse | release_pulse;
    end
    check_bit("stress_activity", logic'(pulses > 1), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
